// File: rtl/seq_tx_1010.sv
// Serial frame transmitter: 1010 preamble, MSB-first payload, then GAP_CYCLES idle zeros.
// Optional even-parity bit after the payload when SEQ_TX_PARITY_EN is defined.
module seq_tx_1010 #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  data_out,
    output logic                  frame_active,
    output logic                  frame_done
);
    // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE, tx_data is sampled only on that edge.

    localparam int M1 = (DATA_WIDTH > 4) ? DATA_WIDTH : 4;
    localparam int M2 = (GAP_CYCLES > M1) ? GAP_CYCLES : M1;
    localparam int CW = $clog2(M2 + 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_PRE  = CW'(3);
    localparam logic [CW-1:0] C_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] C_GAP  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic                  dout_next, fa_next, fd_next;
`ifdef SEQ_TX_PARITY_EN
    logic                  par_q, par_next;
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    assign tx_ready = (state == IDLE);

    // Outputs are computed for the state being entered and registered with it,
    // so data_out/frame_active/frame_done always line up with the current state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_next = shift;
        dout_next  = 1'b0;
        fa_next    = 1'b0;
        fd_next    = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_next   = par_q;
`endif
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_next = PRE;
                    cnt_next   = C_PRE;
                    shift_next = tx_data;
`ifdef SEQ_TX_PARITY_EN
                    par_next   = ^tx_data;
`endif
                    dout_next  = 1'b1;
                    fa_next    = 1'b1;
                end
            end
            PRE: begin
                fa_next = 1'b1;
                if (cnt == '0) begin
                    state_next = DATA;
                    cnt_next   = C_DATA;
                    dout_next  = shift[DATA_WIDTH-1];
                    shift_next = shift << 1;
                    fd_next    = !HAS_PAR && (DATA_WIDTH == 1);
                end else begin
                    cnt_next  = cnt - C_ONE;
                    // Remaining preamble count 3,2,1 precedes bits 0,1,0.
                    dout_next = ~cnt[0];
                end
            end
            DATA: begin
                if (cnt == '0) begin
`ifdef SEQ_TX_PARITY_EN
                    state_next = PAR;
                    dout_next  = par_q;
                    fa_next    = 1'b1;
                    fd_next    = 1'b1;
`else
                    if (GAP_CYCLES != 0) begin
                        state_next = GAP;
                        cnt_next   = C_GAP;
                    end else begin
                        state_next = IDLE;
                    end
`endif
                end else begin
                    cnt_next   = cnt - C_ONE;
                    dout_next  = shift[DATA_WIDTH-1];
                    shift_next = shift << 1;
                    fa_next    = 1'b1;
                    fd_next    = !HAS_PAR && (cnt == C_ONE);
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                if (GAP_CYCLES != 0) begin
                    state_next = GAP;
                    cnt_next   = C_GAP;
                end else begin
                    state_next = IDLE;
                end
            end
`endif
            GAP: begin
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - C_ONE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                shift_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shift        <= '0;
            data_out     <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            shift        <= shift_next;
            data_out     <= dout_next;
            frame_active <= fa_next;
            frame_done   <= fd_next;
`ifdef SEQ_TX_PARITY_EN
            par_q        <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_seq_tx_1010.sv
// Bench for seq_tx_1010: per-cycle vector table on an 8-bit/2-gap instance,
// plus hand-written sequences for the A5 frame and a 4-bit/no-gap instance.
module tb_seq_tx_1010;
  localparam int DW  = 8;
  localparam int GAP = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset, tx_valid, tx_ready, data_out, frame_active, frame_done;
  logic [DW-1:0] tx_data;
  logic b_reset, b_valid, b_ready, b_dout, b_fa, b_fd;
  logic [3:0] b_data;

  seq_tx_1010 #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .data_out(data_out), .frame_active(frame_active),
    .frame_done(frame_done)
  );

  seq_tx_1010 #(.DATA_WIDTH(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(b_reset), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .data_out(b_dout), .frame_active(b_fa),
    .frame_done(b_fd)
  );

  // clock / reset
  always #5 clk = ~clk;

  // exp packs {data_out, tx_ready, frame_active, frame_done}
  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic void add_row(input logic r, input logic v, input logic [7:0] d,
                                  input logic [3:0] e);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.exp = e;
    vecs.push_back(x);
  endfunction

  // Handshake row (idle outputs), then one row per output cycle of the frame.
  // abort_at > 0 asserts reset on that cycle and stops the frame there.
  function automatic void add_frame(input logic [7:0] d, input logic hold, input int abort_at);
    int total;
    logic dout, fa, fd;
    total = 4 + DW + PAR + GAP;
    add_row(1'b0, 1'b1, d, 4'b0100);
    for (int c = 1; c <= total; c++) begin
      dout = 1'b0; fa = 1'b0; fd = 1'b0;
      if (c <= 4) begin
        dout = (c % 2 == 1); fa = 1'b1;
      end else if (c <= 4 + DW) begin
        dout = d[DW-1-(c-5)]; fa = 1'b1; fd = (PAR == 0) && (c == 4 + DW);
      end else if (c <= 4 + DW + PAR) begin
        dout = ^d; fa = 1'b1; fd = 1'b1;
      end
      add_row(c == abort_at, hold, 8'($urandom), {dout, 1'b0, fa, fd});
      if (c == abort_at) return;
    end
  endfunction

  // driver tasks
  task automatic drive_a(input logic r, input logic v, input logic [7:0] d);
    reset = r; tx_valid = v; tx_data = d;
  endtask

  task automatic drive_b(input logic r, input logic v, input logic [3:0] d);
    b_reset = r; b_valid = v; b_data = d;
  endtask

  initial begin
    logic [4+DW+PAR+GAP-1:0] got_bits;
    logic [4+DW+PAR+GAP-1:0] want_bits;
    logic [7:0] b_bits;
    logic [3:0] e;

    drive_a(1'b1, 1'b0, 8'h00);
    drive_b(1'b1, 1'b0, 4'h0);
    repeat (2) @(posedge clk);

    // vector table
    for (int i = 0; i < 5; i++) add_row(1'b0, 1'b0, 8'h00, 4'b0100);
    add_frame(8'hA5, 1'b0, 0);
    add_row(1'b0, 1'b0, 8'h00, 4'b0100);
    add_frame(8'hFF, 1'b1, 0);
    add_frame(8'h00, 1'b0, 0);
    add_row(1'b0, 1'b0, 8'h00, 4'b0100);
    add_frame(8'hC3, 1'b0, 7);
    add_frame(8'h5A, 1'b0, 0);
    add_frame(8'h07, 1'b0, 0);
    add_frame(8'h01, 1'b1, 0);
    add_row(1'b0, 1'b0, 8'h00, 4'b0100);
    add_row(1'b0, 1'b0, 8'h00, 4'b0100);

    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("row%0d", i), {28'd0, data_out, tx_ready, frame_active, frame_done},
            {28'd0, vecs[i].exp});
      drive_a(vecs[i].rst, vecs[i].valid, vecs[i].data);
    end

    // A5 frame: whole serial pattern against a literal, then tx_ready return
`ifdef SEQ_TX_PARITY_EN
    want_bits = 15'b1010_10100101_0_00;
`else
    want_bits = 14'b1010_10100101_00;
`endif
    @(negedge clk);
    drive_a(1'b0, 1'b1, 8'hA5);
    got_bits = '0;
    for (int c = 1; c <= 4 + DW + PAR + GAP; c++) begin
      @(negedge clk);
      got_bits = {got_bits[4+DW+PAR+GAP-2:0], data_out};
      check($sformatf("a5_ready_c%0d", c), {31'd0, tx_ready}, 32'd0);
      drive_a(1'b0, 1'b0, 8'($urandom));
    end
    check("a5_bits", 32'(got_bits), 32'(want_bits));
    @(negedge clk);
    check("a5_ready_back", {31'd0, tx_ready}, 32'd1);

    // 4-bit, no-gap instance: scoreboard of expected output tuples
    drive_b(1'b0, 1'b0, 4'h0);
    @(negedge clk);
    check("b_idle", {28'd0, b_dout, b_ready, b_fa, b_fd}, 32'b0100);
    drive_b(1'b0, 1'b1, 4'b1010);
    b_bits = 8'b1010_1010;
    for (int c = 7; c >= 0; c--) begin
      e = {b_bits[c], 1'b0, 1'b1, (PAR == 0) && (c == 0)};
      exp_q.push_back(e);
    end
`ifdef SEQ_TX_PARITY_EN
    exp_q.push_back(4'b0011);
`endif
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      drive_b(1'b0, 1'b0, 4'($urandom));
      e = exp_q.pop_front();
      check($sformatf("b_c%0d", c), {28'd0, b_dout, b_ready, b_fa, b_fd}, {28'd0, e});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
